// File: rtl/inst_fetch_mem.sv
// inst_fetch_mem
//   Instruction memory for the fetch stage. Accepts one byte-addressed fetch
//   request at a time over a valid/ready handshake and returns the addressed
//   word LATENCY cycles after acceptance, counting the accept edge as the
//   first. Misaligned or out-of-range addresses return a zero word with the
//   fault flag set. A synchronous program-load port writes the array in any
//   state.
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_req_valid    fetch request present
//   o_req_ready    request can be accepted (IDLE only)
//   i_req_addr     byte address of the instruction
//   o_rsp_valid    response present
//   i_rsp_ready    consumer accepts the response
//   o_rsp_instr    fetched word, 0 on fault
//   o_rsp_fault    misaligned or out-of-range request
//   i_prog_we      program-load write enable
//   i_prog_addr    word index for program load
//   i_prog_data    word to write
//
// state  | meaning
// IDLE   | ready for a request
// WAIT   | counting down the read latency
// RESP   | response held until the consumer takes it
module inst_fetch_mem #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_instr,
    output logic              o_rsp_fault,
    input  logic              i_prog_we,
    input  logic [AW-1:0]     i_prog_addr,
    input  logic [DATA_W-1:0] i_prog_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic       L_ONE   = (LATENCY == 1);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rsp_valid;
    logic              r_rsp_fault;
    logic [DATA_W-1:0] r_rsp_instr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_fault;
    logic              w_prog_ok;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic [ADDR_W-3:0] w_idx;

    assign o_req_ready  = (r_state == ST_IDLE);
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_instr  = r_rsp_instr;
    assign o_rsp_fault  = r_rsp_fault;

    assign w_accept     = i_req_valid && o_req_ready;
    assign w_enter_resp = (w_accept && L_ONE) || ((r_state == ST_WAIT) && (r_cnt == 4'd1));

    // With single-cycle latency the response is captured on the accept edge,
    // before the address register has been loaded, so read the live address.
    assign w_fetch_addr = (r_state == ST_IDLE) ? i_req_addr : r_addr;
    assign w_idx        = w_fetch_addr[ADDR_W-1:2];
    assign w_fault      = (w_fetch_addr[1:0] != 2'b00) || (w_idx >= (ADDR_W-2)'(DEPTH));

    // Only a non-power-of-two depth can see program indices past the array.
    if (DEPTH == (1 << AW)) begin : g_pow2
        assign w_prog_ok = 1'b1;
    end else begin : g_npow2
        assign w_prog_ok = ({1'b0, i_prog_addr} < (AW+1)'(DEPTH));
    end

    // Array has no reset; program load is independent of the fetch FSM.
    always_ff @(posedge i_clk) begin
        if (i_prog_we && w_prog_ok) begin
            r_mem[i_prog_addr] <= i_prog_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_instr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= i_req_addr;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= L_ONE ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Read happens on the RESP-entry edge, so a write on that same
            // edge is not seen (read-before-write).
            if (w_enter_resp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_fault <= w_fault;
                r_rsp_instr <= w_fault ? '0 : r_mem[w_idx[AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Bench for inst_fetch_mem: four instances with LATENCY 1, 2, 3 and 15 share
// clock and reset; each has its own request/program signals. A word-array
// model per instance supplies expected data.
module tb_inst_fetch_mem;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req_valid;
    logic [3:0]        req_ready;
    logic [3:0][63:0]  req_addr;
    logic [3:0]        rsp_valid;
    logic [3:0]        rsp_ready;
    logic [3:0][31:0]  rsp_instr;
    logic [3:0]        rsp_fault;
    logic [3:0]        prog_we;
    logic [3:0][7:0]   prog_addr;
    logic [3:0][31:0]  prog_data;

    logic [31:0] mdl_mem [4][256];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        inst_fetch_mem #(
            .ADDR_W (64),
            .DATA_W (32),
            .DEPTH  (256),
            .LATENCY(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 3 : 15)
        ) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_req_valid(req_valid[g]),
            .o_req_ready(req_ready[g]),
            .i_req_addr (req_addr[g]),
            .o_rsp_valid(rsp_valid[g]),
            .i_rsp_ready(rsp_ready[g]),
            .o_rsp_instr(rsp_instr[g]),
            .o_rsp_fault(rsp_fault[g]),
            .i_prog_we  (prog_we[g]),
            .i_prog_addr(prog_addr[g]),
            .i_prog_data(prog_data[g])
        );
    end

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    function automatic logic is_fault(input logic [63:0] a);
        return (a % 4 != 0) || ((a / 4) >= 256);
    endfunction

    function automatic logic [31:0] exp_word(input int k, input logic [63:0] a);
        if (is_fault(a)) return 32'h0;
        return mdl_mem[k][int'(a / 4)];
    endfunction

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return (64'($urandom_range(0, 255)) * 4) + 64'($urandom_range(1, 3));
        if (r == 1) return 64'($urandom_range(256, 4000)) * 4;
        return 64'($urandom_range(0, 255)) * 4;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prog(input int k, input int a, input logic [31:0] d);
        prog_we[k]   = 1'b1;
        prog_addr[k] = 8'(a);
        prog_data[k] = d;
        @(posedge clk); #1;
        prog_we[k]   = 1'b0;
        mdl_mem[k][a] = d;
    endtask

    task automatic fetch(input int k, input logic [63:0] addr, input int hold);
        int n;
        logic [31:0] ei;
        logic ef;
        ef = is_fault(addr);
        ei = exp_word(k, addr);
        check("idle_req_ready", 64'(req_ready[k]), 64'd1);
        req_valid[k] = 1'b1;
        req_addr[k]  = addr;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        n = 1;
        while (!rsp_valid[k] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(lat_of(k)));
        check("rsp_valid", 64'(rsp_valid[k]), 64'd1);
        check("rsp_instr", 64'(rsp_instr[k]), 64'(ei));
        check("rsp_fault", 64'(rsp_fault[k]), 64'(ef));
        check("busy_req_ready", 64'(req_ready[k]), 64'd0);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(rsp_valid[k]), 64'd1);
            check("hold_instr", 64'(rsp_instr[k]), 64'(ei));
            check("hold_req_ready", 64'(req_ready[k]), 64'd0);
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
        check("retire_valid", 64'(rsp_valid[k]), 64'd0);
        check("retire_req_ready", 64'(req_ready[k]), 64'd1);
        check("post_retire_instr", 64'(rsp_instr[k]), 64'(ei));
    endtask

    task automatic stream(input int k, input int n);
        logic [63:0] addrs[$];
        int acc_cyc[$];
        int nacc, nrsp, cyc, last_acc;
        logic acc;
        for (int i = 0; i < n; i++) addrs.push_back(rand_addr());
        nacc = 0; nrsp = 0; cyc = 0; last_acc = -1;
        rsp_ready[k] = 1'b1;
        req_valid[k] = 1'b1;
        req_addr[k]  = addrs[0];
        while (nrsp < n && cyc < 600) begin
            acc = req_valid[k] && req_ready[k];
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (last_acc >= 0) check("stream_period", 64'(cyc - last_acc), 64'(lat_of(k) + 1));
                last_acc = cyc;
                acc_cyc.push_back(cyc);
                nacc++;
                if (nacc == n) req_valid[k] = 1'b0;
                else req_addr[k] = addrs[nacc];
            end
            if (rsp_valid[k]) begin
                if (nrsp < acc_cyc.size()) begin
                    check("stream_instr", 64'(rsp_instr[k]), 64'(exp_word(k, addrs[nrsp])));
                    check("stream_fault", 64'(rsp_fault[k]), 64'(is_fault(addrs[nrsp])));
                    check("stream_latency", 64'(cyc - acc_cyc[nrsp] + 1), 64'(lat_of(k)));
                end else begin
                    check("stream_unrequested_rsp", 64'(nrsp), 64'(acc_cyc.size()));
                end
                nrsp++;
            end
        end
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
        req_valid[k] = 1'b0;
        check("stream_rsp_count", 64'(nrsp), 64'(n));
        check("stream_acc_count", 64'(nacc), 64'(n));
        check("stream_end_valid", 64'(rsp_valid[k]), 64'd0);
    endtask

    initial begin
        logic seen;
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = '0;
        prog_we   = '0;
        prog_addr = '0;
        prog_data = '0;
        #12;
        for (int k = 0; k < 4; k++) begin
            check("reset_req_ready", 64'(req_ready[k]), 64'd1);
            check("reset_rsp_valid", 64'(rsp_valid[k]), 64'd0);
            check("reset_rsp_instr", 64'(rsp_instr[k]), 64'd0);
            check("reset_rsp_fault", 64'(rsp_fault[k]), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // load every word of every instance with random data
        for (int a = 0; a < 256; a++) begin
            for (int k = 0; k < 4; k++) begin
                prog_we[k]   = 1'b1;
                prog_addr[k] = 8'(a);
                prog_data[k] = $urandom;
                mdl_mem[k][a] = prog_data[k];
            end
            @(posedge clk); #1;
        end
        prog_we = '0;

        // basic fetch, latency 2
        prog(1, 0, 32'h8B1F03E5);
        prog(1, 1, 32'hF84000A4);
        fetch(1, 64'h4, 0);
        fetch(1, 64'h0, 0);

        // faults: misaligned, past depth, high address bits
        fetch(1, 64'h6, 0);
        fetch(1, 64'h400, 0);
        fetch(1, 64'h8000_0000_0000_0004, 0);
        fetch(1, 64'h3FC, 0);

        // consumer stall
        fetch(1, 64'h8, 5);

        // write ordering against the RESP-entry edge, latency 3
        prog(2, 2, 32'h11111111);
        req_valid[2] = 1'b1;
        req_addr[2]  = 64'h8;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        prog_we[2] = 1'b1; prog_addr[2] = 8'd2; prog_data[2] = 32'h8B040086;
        @(posedge clk); #1;
        prog_we[2] = 1'b0;
        mdl_mem[2][2] = 32'h8B040086;
        @(posedge clk); #1;
        check("early_write_valid", 64'(rsp_valid[2]), 64'd1);
        check("early_write_instr", 64'(rsp_instr[2]), 64'h8B040086);
        rsp_ready[2] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[2] = 1'b0;
        req_valid[2] = 1'b1;
        req_addr[2]  = 64'h8;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        prog_we[2] = 1'b1; prog_addr[2] = 8'd2; prog_data[2] = 32'h12345678;
        @(posedge clk); #1;
        prog_we[2] = 1'b0;
        mdl_mem[2][2] = 32'h12345678;
        check("same_edge_write_valid", 64'(rsp_valid[2]), 64'd1);
        check("same_edge_write_instr", 64'(rsp_instr[2]), 64'h8B040086);
        prog(2, 2, 32'hCAFEF00D);
        check("held_after_write", 64'(rsp_instr[2]), 64'h8B040086);
        rsp_ready[2] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[2] = 1'b0;
        fetch(2, 64'h8, 0);

        // random single fetches across instances
        for (int i = 0; i < 10; i++) begin
            fetch(int'($urandom_range(0, 3)), rand_addr(), int'($urandom_range(0, 2)));
        end

        // reset during WAIT abandons the fetch
        req_valid[3] = 1'b1;
        req_addr[3]  = 64'h10;
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("wait_req_ready", 64'(req_ready[3]), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_req_ready", 64'(req_ready[3]), 64'd1);
        check("midreset_rsp_valid", 64'(rsp_valid[3]), 64'd0);
        check("midreset_rsp_instr", 64'(rsp_instr[3]), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            seen = seen | rsp_valid[3];
        end
        check("no_rsp_after_reset", 64'(seen), 64'd0);
        fetch(3, 64'h10, 0);
        fetch(3, 64'h3FC, 0);
        fetch(1, 64'h4, 0);

        // back-to-back streaming at the latency extremes
        stream(0, 8);
        stream(3, 6);
        stream(1, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
